// File: rtl/flag_unit_if.sv
// Execute-side flag bus between the pipeline and flag_unit.
// master drives the execute-stage inputs; slave is the flag unit.
interface flag_unit_if;
    logic       FlagWriteE;
    logic [3:0] ALUFlagsE;
    logic       FlushE;
    logic       StallB;
    logic [2:0] OpcodeE;
    logic [1:0] SE;
    logic [3:0] Flags;
    logic [3:0] ArchFlags;
    logic       FlagsBusy;
    logic       FlagHazard;

    modport master (
        output FlagWriteE, ALUFlagsE, FlushE, StallB, OpcodeE, SE,
        input  Flags, ArchFlags, FlagsBusy, FlagHazard
    );

    modport slave (
        input  FlagWriteE, ALUFlagsE, FlushE, StallB, OpcodeE, SE,
        output Flags, ArchFlags, FlagsBusy, FlagHazard
    );
endinterface

// File: rtl/flag_unit.sv
// NZCV flag register with a STAGES-deep in-flight write pipe from execute to commit.
// Define FLAG_FORWARD_EN to forward in-flight flags; otherwise branches raise FlagHazard.
module flag_unit #(
    parameter int STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    flag_unit_if.slave  bus
);

    localparam logic [2:0] OP_BRANCH = 3'b110;
    localparam logic [1:0] SE_ALWAYS = 2'b11;

    logic [STAGES-1:0] r_valid;
    logic [3:0]        r_flags [STAGES];
    logic [3:0]        r_arch;

    logic              w_insert_valid;
    logic              w_busy;
    logic [3:0]        w_flags_view;
    logic              w_hazard;

    assign w_insert_valid = bus.FlagWriteE & ~bus.FlushE;
    assign w_busy         = |r_valid;

    // In-flight pipe shift and architectural commit; everything freezes on backend stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_arch  <= 4'b0000;
            for (int i = 0; i < STAGES; i++) begin
                r_flags[i] <= 4'b0000;
            end
        end else if (!bus.StallB) begin
            r_valid[0] <= w_insert_valid;
            r_flags[0] <= bus.ALUFlagsE;
            for (int i = 1; i < STAGES; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_flags[i] <= r_flags[i-1];
            end
            if (r_valid[STAGES-1]) begin
                r_arch <= r_flags[STAGES-1];
            end else begin
                r_arch <= r_arch;
            end
        end else begin
            r_valid <= r_valid;
            r_arch  <= r_arch;
        end
    end

`ifdef FLAG_FORWARD_EN
    // Youngest valid entry wins: scan oldest to youngest so lower indices overwrite.
    always_comb begin
        w_flags_view = r_arch;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_flags_view = r_valid[i] ? r_flags[i] : w_flags_view;
        end
        w_hazard = 1'b0;
    end
`else
    // Without forwarding only committed flags are visible, so a conditional branch must wait.
    always_comb begin
        w_flags_view = r_arch;
        if ((bus.OpcodeE == OP_BRANCH) && (bus.SE != SE_ALWAYS)) begin
            w_hazard = w_busy;
        end else begin
            w_hazard = 1'b0;
        end
    end
`endif

    assign bus.Flags      = w_flags_view;
    assign bus.ArchFlags  = r_arch;
    assign bus.FlagsBusy  = w_busy;
    assign bus.FlagHazard = w_hazard;

endmodule

// File: tb/tb_flag_unit.sv
// Directed plus random stimulus for flag_unit, checked against a queue-based model
// of pending flag writes (each aged in advance cycles until it commits).
module tb_flag_unit;

    localparam int STAGES = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    flag_unit_if bus ();

    flag_unit #(.STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] f;
        int         age;
    } pend_t;

    pend_t      q[$];
    logic [3:0] m_arch;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, take the edge, update the model.
    task automatic cyc(input logic r, input logic fw, input logic [3:0] alu, input logic fl,
                       input logic st, input logic [2:0] op, input logic [1:0] se);
        logic [3:0] e_flags;
        logic       e_busy;
        logic       e_haz;
        pend_t      p;
        rst            = r;
        bus.FlagWriteE = fw;
        bus.ALUFlagsE  = alu;
        bus.FlushE     = fl;
        bus.StallB     = st;
        bus.OpcodeE    = op;
        bus.SE         = se;
        #1;
        e_busy = (q.size() != 0);
`ifdef FLAG_FORWARD_EN
        e_flags = e_busy ? q[q.size()-1].f : m_arch;
        e_haz   = 1'b0;
`else
        e_flags = m_arch;
        e_haz   = (op == 3'b110) && (se != 2'b11) && e_busy;
`endif
        check("Flags", bus.Flags, e_flags);
        check("ArchFlags", bus.ArchFlags, m_arch);
        check("FlagsBusy", {3'b000, bus.FlagsBusy}, {3'b000, e_busy});
        check("FlagHazard", {3'b000, bus.FlagHazard}, {3'b000, e_haz});
        @(posedge clk);
        if (r) begin
            q.delete();
            m_arch = 4'b0000;
        end else if (!st) begin
            foreach (q[i]) q[i].age++;
            if (q.size() != 0 && q[0].age == STAGES) begin
                m_arch = q[0].f;
                void'(q.pop_front());
            end
            if (fw && !fl) begin
                p.f   = alu;
                p.age = 0;
                q.push_back(p);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 3'b000, 2'b00);
    endtask

    initial begin
        bus.FlagWriteE = 1'b0;
        bus.ALUFlagsE  = 4'b0000;
        bus.FlushE     = 1'b0;
        bus.StallB     = 1'b0;
        bus.OpcodeE    = 3'b000;
        bus.SE         = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        m_arch = 4'b0000;
        q.delete();

        idle(3);
        // single write, then commit
        cyc(1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 3'b000, 2'b00);
        idle(3);
        // back-to-back writes
        cyc(1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 3'b000, 2'b00);
        cyc(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 3'b000, 2'b00);
        idle(3);
        // flushed write never becomes valid
        cyc(1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 3'b000, 2'b00);
        idle(2);
        // stall holds in-flight entry; FlagWriteE ignored while stalled
        cyc(1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 3'b000, 2'b00);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'b1000, 1'b0, 1'b1, 3'b000, 2'b00);
        idle(3);
        // conditional branch behind a write
        cyc(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 3'b000, 2'b00);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 3'b110, 2'b00);
        // always-branch never needs flags
        cyc(1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 3'b000, 2'b00);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 3'b110, 2'b11);
        // reset mid-flight discards pending writes
        cyc(1'b0, 1'b1, 4'b1001, 1'b0, 1'b0, 3'b000, 2'b00);
        cyc(1'b1, 1'b1, 4'b0011, 1'b0, 1'b0, 3'b000, 2'b00);
        idle(3);

        for (int i = 0; i < 500; i++) begin
            cyc(($urandom_range(0, 59) == 0),
                ($urandom_range(0, 2) != 0),
                4'($urandom_range(0, 15)),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 1) == 0) ? 3'b110 : 3'($urandom_range(0, 7)),
                2'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Owns the architectural NZCV flag register and the in-flight flag writes between execute and writeback.
- Flag-setting instructions produce ALU flags in execute, but the flags commit STAGES cycles later.
- Feeds condition_checker the current flag view for the instruction in execute: the youngest in-flight write, or the architectural flags.
- Raises a hazard when forwarding is compiled out.

Parameters:
- STAGES, 2, number of in-flight entries between execute and flag commit; legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- FlagWriteE  in  1  instruction in execute writes flags
- ALUFlagsE  in  4  flags from the ALU; bit order [0]=N [1]=Z [2]=C [3]=V
- FlushE  in  1  execute instruction is squashed
- StallB  in  1  backend stall; in-flight entries hold
- OpcodeE  in  3  opcode of the instruction in execute
- SE  in  2  condition select of the instruction in execute
- Flags  out  4  flag view for condition_checker; same bit order as ALUFlagsE
- ArchFlags  out  4  committed architectural flags
- FlagsBusy  out  1  at least one in-flight entry is valid
- FlagHazard  out  1  the branch in execute must stall

Behaviour:
- State:
  - ArchFlags register, 4 bits.
  - Entry array e[0..STAGES-1], each holding {valid, flags[3:0]}.
  - e[0] is the youngest entry, e[STAGES-1] the oldest.
- Reset (rst=1 at a clk edge):
  - All valid bits cleared; ArchFlags=4'b0000.
  - Flags=0, FlagsBusy=0, FlagHazard=0 in the cycle after reset.
  - Reset mid-operation discards all in-flight writes; none commit.
- Advance (StallB=0):
  - e[i] <= e[i-1] for i>=1.
  - e[0] <= {FlagWriteE & ~FlushE, ALUFlagsE}.
  - If e[STAGES-1].valid, ArchFlags <= e[STAGES-1].flags in the same edge.
- Hold (StallB=1):
  - All entries and ArchFlags hold.
  - FlagWriteE is ignored; the stalled execute instruction re-presents it.
- FlushE affects only the insert. Older entries are never squashed, since they are past execute.
- Latency: flags inserted at edge k commit to ArchFlags at edge k+STAGES, with no stalls in between.
- FlagsBusy = OR of all valid bits; combinational.
- Flags (combinational, forwarding enabled): flags of the lowest-index valid entry; ArchFlags if none is valid.
  - Execute never sees its own write, because the insert happens at the edge.
- Back-to-back writes: each flag-setting instruction gets its own entry. The younger entry always wins the forward.
- STAGES=1: e[0] is both insert and commit slot; forwarding degenerates to e[0] or ArchFlags.
- FlagHazard: defined under Optional Feature. The unit itself never stalls; FlagHazard is a request to the hazard unit.
- Only branch opcode 3'b110 consumes flags. SE=2'b11 (always) never needs flags.

Optional Feature:
- Macro: FLAG_FORWARD_EN.
- Defined:
  - Forwarding as above.
  - FlagHazard tied to 0.
- Undefined:
  - Flags = ArchFlags always.
  - FlagHazard = (OpcodeE==3'b110) & (SE!=2'b11) & FlagsBusy, combinational.
  - The hazard unit stalls fetch/decode/execute but not the backend, so entries drain and the hazard clears after at most STAGES non-stalled cycles.

Test Plan:
- Reset, then idle 3 cycles -> Flags=0, ArchFlags=0, FlagsBusy=0, FlagHazard=0.
- STAGES=2, forwarding on; FlagWriteE=1, ALUFlagsE=4'b0010 for one cycle, then FlagWriteE=0 -> Flags=4'b0010 the next cycle; ArchFlags=4'b0010 two edges after the insert; FlagsBusy drops after commit.
- Forwarding on; back-to-back writes 4'b0010 then 4'b0001 -> after the second edge Flags=4'b0001 while ArchFlags=0. After two more edges ArchFlags=4'b0001.
- FlagWriteE=1, ALUFlagsE=4'b1111, FlushE=1 -> no entry becomes valid; FlagsBusy=0; Flags and ArchFlags unchanged at 0.
- In-flight 4'b0010 with StallB=1 held for 3 cycles -> ArchFlags stays 0 and FlagsBusy stays 1 throughout. After StallB drops, ArchFlags=4'b0010 after the remaining edges.
- Forwarding off, STAGES=2; write 4'b0010, then OpcodeE=3'b110, SE=2'b00 ->
  - FlagHazard=1 for 2 cycles, then 0 with Flags=4'b0010.
  - With SE=2'b11, FlagHazard=0 throughout.
